ram_arbiter: RTL and testbench

Shares the single RAM port between the coherence controller's data channel and the two per-core instruction-cache fill channels. Data requests have fixed priority, and the two icaches alternate round-robin. A locked data burst, such as a two-word block write-back or load, holds the port until the burst completes. The block sits between the coherence controller and the RAM model, inside the memory-control wrapper.

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/ram_arbiter_if.sv | 36 +++
 rtl/starve_counter.sv | 32 +++
 rtl/ram_arbiter.sv | 135 +++++++++++++
 tb/tb_ram_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: word and RAM handshake state, plus the RAM arbiter's
// FSM state and icache owner encodings.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE,
    DGRANT,
    IGRANT
  } arb_state_t;

  typedef enum logic {
    I0,
    I1
  } arb_owner_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of the data channel, both icache fill channels and the RAM port.
// The arbiter uses the slave view; the surrounding system drives the master view.
interface ram_arbiter_if;
  import cpu_types_pkg::*;

  logic             d_req;
  logic             d_wen;
  logic             d_lock;
  word_t            d_addr;
  word_t            d_store;
  logic             d_wait;
  word_t            d_load;

  logic [1:0]       i_ren;
  word_t [1:0]      i_addr;
  logic [1:0]       i_wait;
  word_t [1:0]      i_load;

  word_t            ramaddr;
  word_t            ramstore;
  logic             ramREN;
  logic             ramWEN;
  word_t            ramload;
  ramstate_t        ramstate;

  modport slave (
    input  d_req, d_wen, d_lock, d_addr, d_store, i_ren, i_addr, ramload, ramstate,
    output d_wait, d_load, i_wait, i_load, ramaddr, ramstore, ramREN, ramWEN
  );

  modport master (
    output d_req, d_wen, d_lock, d_addr, d_store, i_ren, i_addr, ramload, ramstate,
    input  d_wait, d_load, i_wait, i_load, ramaddr, ramstore, ramREN, ramWEN
  );

endinterface

// File: rtl/starve_counter.sv
// Saturating wait counter for one icache core; hit flags a core that has waited
// STARVE_LIMIT cycles. Only built when ARB_STARVE_EN is defined.
`ifdef ARB_STARVE_EN
module starve_counter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic CLK,
  input  logic nRST,
  input  logic req,
  input  logic granted,
  output logic hit
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      r_cnt <= '0;
    end else if (granted || !req) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_W'(STARVE_LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Gate with req so a stale count never wins in the cycle the request drops.
  assign hit = req && (r_cnt == CNT_W'(STARVE_LIMIT));

endmodule
`endif

// File: rtl/ram_arbiter.sv
// Single RAM port shared by the data channel (fixed priority, lockable bursts) and
// two round-robin icache fill channels. Define ARB_STARVE_EN for icache anti-starvation.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic         CLK,
  input  logic         nRST,
  ram_arbiter_if.slave bus
);

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  arb_state_t r_state, w_state_nxt;
  arb_owner_t r_owner, w_owner_nxt;
  logic       r_rr, w_rr_nxt;
  logic       w_own;
  logic [1:0] w_hit;

  assign w_own = (r_owner == I1);

`ifdef ARB_STARVE_EN
  for (genvar k = 0; k < 2; k++) begin : g_starve
    starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
      .CLK     (CLK),
      .nRST    (nRST),
      .req     (bus.i_ren[k]),
      .granted ((r_state == IGRANT) && (w_own == 1'(k))),
      .hit     (w_hit[k])
    );
  end
`else
  assign w_hit = 2'b00;
`endif

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_owner <= I0;
      r_rr    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_rr    <= w_rr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr;
    case (r_state)
      IDLE: begin
        // A starved icache outranks data; otherwise data first, then round-robin.
        if (w_hit[r_rr]) begin
          w_state_nxt = IGRANT;
          w_owner_nxt = arb_owner_t'(r_rr);
        end else if (w_hit[!r_rr]) begin
          w_state_nxt = IGRANT;
          w_owner_nxt = arb_owner_t'(!r_rr);
        end else if (bus.d_req) begin
          w_state_nxt = DGRANT;
        end else if (bus.i_ren[r_rr]) begin
          w_state_nxt = IGRANT;
          w_owner_nxt = arb_owner_t'(r_rr);
        end else if (bus.i_ren[!r_rr]) begin
          w_state_nxt = IGRANT;
          w_owner_nxt = arb_owner_t'(!r_rr);
        end
      end
      DGRANT: begin
        if (bus.ramstate == ACCESS) begin
          if (!bus.d_lock) w_state_nxt = IDLE;
        end else if (!bus.d_req && !bus.d_lock) begin
          w_state_nxt = IDLE;
        end
      end
      IGRANT: begin
        if (bus.ramstate == ACCESS) begin
          w_state_nxt = IDLE;
          w_rr_nxt    = !w_own;
        end else if (!bus.i_ren[w_own]) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  word_t       w_ramaddr, w_ramstore, w_d_load;
  word_t [1:0] w_i_load;
  logic        w_ramREN, w_ramWEN, w_d_wait;
  logic  [1:0] w_i_wait;

  always_comb begin
    w_ramaddr  = '0;
    w_ramstore = '0;
    w_ramREN   = 1'b0;
    w_ramWEN   = 1'b0;
    w_d_wait   = 1'b1;
    w_d_load   = '0;
    w_i_wait   = 2'b11;
    w_i_load   = '0;
    case (r_state)
      DGRANT: begin
        w_ramaddr  = bus.d_addr;
        w_ramstore = bus.d_wen ? bus.d_store : '0;
        w_ramWEN   = bus.d_wen;
        w_ramREN   = !bus.d_wen;
        w_d_wait   = (bus.ramstate != ACCESS);
        w_d_load   = bus.ramload;
      end
      IGRANT: begin
        w_ramaddr       = bus.i_addr[w_own];
        w_ramREN        = 1'b1;
        w_i_wait[w_own] = (bus.ramstate != ACCESS);
        w_i_load[w_own] = bus.ramload;
      end
      default: ;
    endcase
  end

  assign bus.ramaddr  = w_ramaddr;
  assign bus.ramstore = w_ramstore;
  assign bus.ramREN   = w_ramREN;
  assign bus.ramWEN   = w_ramWEN;
  assign bus.d_wait   = w_d_wait;
  assign bus.d_load   = w_d_load;
  assign bus.i_wait   = w_i_wait;
  assign bus.i_load   = w_i_load;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed scoreboard bench for ram_arbiter: a small RAM model answers after a
// fixed number of BUSY cycles, and every completion is checked against the queue.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  localparam word_t K = 32'h5A5A_0000;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;

  ram_arbiter_if bus ();

  ram_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic  is_d;
    logic  wen;
    int    core;
    word_t addr;
    word_t wdata;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  logic force_busy = 1'b0;
  int   lat = 2;
  logic [3:0] r_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic is_d, input logic wen, input int core,
                      input word_t addr, input word_t wdata);
    exp_t e;
    e.is_d = is_d; e.wen = wen; e.core = core; e.addr = addr; e.wdata = wdata;
    sb.push_back(e);
  endtask

  // RAM model: lat BUSY cycles, then one ACCESS cycle per word
  always @(posedge CLK) begin
    if (!nRST || !(bus.ramREN || bus.ramWEN) || bus.ramstate == ACCESS) r_cnt <= 4'd0;
    else r_cnt <= r_cnt + 4'd1;
  end

  always_comb begin
    if (force_busy) bus.ramstate = BUSY;
    else if (bus.ramREN || bus.ramWEN) bus.ramstate = (r_cnt >= 4'(lat)) ? ACCESS : BUSY;
    else bus.ramstate = FREE;
  end

  assign bus.ramload = bus.ramaddr ^ K;

  // Completion monitor: every low wait must match the head of the scoreboard
  always @(negedge CLK) begin
    logic       dc;
    logic [1:0] ic;
    exp_t       e;
    dc = !bus.d_wait;
    ic = ~bus.i_wait;
    if (nRST && (dc || ic != 2'b00)) begin
      check("single_done", 32'(dc) + 32'(ic[0]) + 32'(ic[1]), 32'd1);
      if (sb.size() == 0) begin
        check("unexpected_done", {29'b0, dc, ic}, 32'd0);
      end else begin
        e = sb.pop_front();
        if (e.is_d) begin
          check("d_done", 32'(dc), 32'd1);
          check("d_ramaddr", bus.ramaddr, e.addr);
          check("d_ramWEN", 32'(bus.ramWEN), 32'(e.wen));
          check("d_ramREN", 32'(bus.ramREN), 32'(!e.wen));
          check("d_ramstore", bus.ramstore, e.wen ? e.wdata : 32'd0);
          check("d_load", bus.d_load, e.addr ^ K);
          check("d_iload0", bus.i_load[0], 32'd0);
          check("d_iload1", bus.i_load[1], 32'd0);
        end else begin
          check("i_lane", {30'b0, ic}, 32'(1 << e.core));
          check("i_ramaddr", bus.ramaddr, e.addr);
          check("i_ramREN", 32'(bus.ramREN), 32'd1);
          check("i_ramWEN", 32'(bus.ramWEN), 32'd0);
          check("i_load_own", bus.i_load[e.core], e.addr ^ K);
          check("i_load_other", bus.i_load[1 - e.core], 32'd0);
          check("i_dload", bus.d_load, 32'd0);
        end
      end
    end
  end

  // Waits for the selected channel's completion, counting enabled cycles on the way,
  // and returns 1 time unit after the edge that ends that cycle.
  task automatic wait_done(input bit is_d, input int core, output int nen);
    bit seen;
    seen = 1'b0;
    nen  = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge CLK);
      if (bus.ramREN || bus.ramWEN) nen++;
      if (is_d ? !bus.d_wait : !bus.i_wait[core]) seen = 1'b1;
    end
    check(is_d ? "timeout_d" : "timeout_i", 32'(seen), 32'd1);
    @(posedge CLK); #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ren"}, 32'(bus.ramREN), 32'd0);
    check({tag, "_wen"}, 32'(bus.ramWEN), 32'd0);
    check({tag, "_dwait"}, 32'(bus.d_wait), 32'd1);
    check({tag, "_iwait"}, 32'(bus.i_wait), 32'd3);
  endtask

  initial begin
    int n;
    bus.d_req = 1'b0; bus.d_wen = 1'b0; bus.d_lock = 1'b0;
    bus.d_addr = '0; bus.d_store = '0;
    bus.i_ren = 2'b00; bus.i_addr = '0;

    // Reset values
    #12;
    check_idle("rst");
    check("rst_ramaddr", bus.ramaddr, 32'd0);
    check("rst_ramstore", bus.ramstore, 32'd0);
    check("rst_dload", bus.d_load, 32'd0);
    check("rst_iload0", bus.i_load[0], 32'd0);
    check("rst_iload1", bus.i_load[1], 32'd0);
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;

    // Single icache fill on core 0: three enabled cycles, completes in the third
    bus.i_addr[0] = 32'h100; bus.i_ren = 2'b01;
    push(1'b0, 1'b0, 0, 32'h100, 32'h0);
    wait_done(1'b0, 0, n);
    check("t1_ren_cycles", 32'(n), 32'd3);
    bus.i_ren = 2'b00;
    check("t1_rr", 32'(dut.r_rr), 32'd1);
    @(negedge CLK); check_idle("t1_after");

    // Locked two-word write burst
    @(posedge CLK); #1;
    bus.d_req = 1'b1; bus.d_wen = 1'b1; bus.d_lock = 1'b1;
    bus.d_addr = 32'h200; bus.d_store = 32'hDEAD_0001;
    push(1'b1, 1'b1, 0, 32'h200, 32'hDEAD_0001);
    wait_done(1'b1, 0, n);
    check("t2_w1_cycles", 32'(n), 32'd3);
    bus.d_lock = 1'b0; bus.d_addr = 32'h204; bus.d_store = 32'hDEAD_0002;
    push(1'b1, 1'b1, 0, 32'h204, 32'hDEAD_0002);
    @(negedge CLK);
    check("t2_no_bubble", 32'(bus.ramWEN), 32'd1);
    check("t2_addr2", bus.ramaddr, 32'h204);
    wait_done(1'b1, 0, n);
    check("t2_w2_cycles", 32'(n), 32'd2);
    bus.d_req = 1'b0; bus.d_wen = 1'b0;
    @(negedge CLK); check_idle("t2_after");

    // Withdrawal of core 1 while BUSY
    @(posedge CLK); #1;
    force_busy = 1'b1; bus.i_addr[1] = 32'h600; bus.i_ren = 2'b10;
    @(posedge CLK); #1;
    @(negedge CLK);
    check("t4_granted", 32'(bus.ramREN), 32'd1);
    check("t4_addr", bus.ramaddr, 32'h600);
    check("t4_iwait", 32'(bus.i_wait), 32'd3);
    @(posedge CLK); #1;
    bus.i_ren = 2'b00;
    @(posedge CLK); #1;
    @(negedge CLK); check_idle("t4_after");
    check("t4_rr", 32'(dut.r_rr), 32'd1);
    force_busy = 1'b0;

    // Core 1 fill flips rr back to 0
    @(posedge CLK); #1;
    bus.i_addr[1] = 32'h700; bus.i_ren = 2'b10;
    push(1'b0, 1'b0, 1, 32'h700, 32'h0);
    wait_done(1'b0, 1, n);
    check("t5_ren_cycles", 32'(n), 32'd3);
    bus.i_ren = 2'b00;
    check("t5_rr", 32'(dut.r_rr), 32'd0);

    // Contention: data, then core 0, then core 1, one IDLE between each
    bus.d_req = 1'b1; bus.d_wen = 1'b0; bus.d_addr = 32'h300;
    bus.i_addr[0] = 32'h400; bus.i_addr[1] = 32'h500; bus.i_ren = 2'b11;
    push(1'b1, 1'b0, 0, 32'h300, 32'h0);
    push(1'b0, 1'b0, 0, 32'h400, 32'h0);
    push(1'b0, 1'b0, 1, 32'h500, 32'h0);
    wait_done(1'b1, 0, n);
    bus.d_req = 1'b0;
    @(negedge CLK); check_idle("t3_bubble1");
    check("t3_rr_after_d", 32'(dut.r_rr), 32'd0);
    wait_done(1'b0, 0, n);
    bus.i_ren = 2'b10;
    @(negedge CLK); check_idle("t3_bubble2");
    wait_done(1'b0, 1, n);
    bus.i_ren = 2'b00;

    // Reset asserted mid-write drops the enables at once
    @(posedge CLK); #1;
    force_busy = 1'b1;
    bus.d_req = 1'b1; bus.d_wen = 1'b1; bus.d_addr = 32'h800; bus.d_store = 32'h1234_5678;
    @(posedge CLK); #1;
    #2 check("t6_wen_before", 32'(bus.ramWEN), 32'd1);
    #1 nRST = 1'b0;
    #1 check("t6_wen_reset", 32'(bus.ramWEN), 32'd0);
    check("t6_dwait_reset", 32'(bus.d_wait), 32'd1);
    bus.d_req = 1'b0; bus.d_wen = 1'b0; force_busy = 1'b0;
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK); check_idle("t6_after");
    check("t6_state", 32'(dut.r_state), 32'(IDLE));

`ifdef ARB_STARVE_EN
    // Starved core 0 overtakes a continuously requesting data channel
    @(posedge CLK); #1;
    bus.d_req = 1'b1; bus.d_wen = 1'b0; bus.d_lock = 1'b0; bus.d_addr = 32'h900;
    bus.i_addr[0] = 32'h180; bus.i_ren = 2'b01;
    push(1'b1, 1'b0, 0, 32'h900, 32'h0);
    push(1'b0, 1'b0, 0, 32'h180, 32'h0);
    push(1'b1, 1'b0, 0, 32'h900, 32'h0);
    wait_done(1'b0, 0, n);
    bus.i_ren = 2'b00;
    wait_done(1'b1, 0, n);
    bus.d_req = 1'b0;
    @(negedge CLK); check_idle("t7_after");
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
